// File: rtl/multi_stream_fifo_bank.sv
// ---------------------------------------------------------------------------
// multi_stream_fifo_bank
//
// Purpose:
//   A bank of LANES independent first-word-fall-through FIFOs. Each lane sits
//   directly behind one output of the broadcast splitter. The lane stores
//   {tlast, tuser, tdata} together. i_tready and o_tvalid are derived only
//   from the lane's registered pointers. A downstream consumer's tready
//   therefore never reaches back into the valid it is handshaking against.
//
// Ports:
//   clk        single clock for all lanes
//   reset_n    asynchronous reset, active-low (clears pointers only)
//   clear      synchronous flush of every lane, active-high
//   i_tdata    LANES x WIDTH input data, lane k at [WIDTH*k +: WIDTH]
//   i_tuser    LANES x USER_WIDTH input user bits, same packing
//   i_tlast    per-lane input last
//   i_tvalid   per-lane input valid
//   i_tready   per-lane input ready (~full)
//   o_tdata    LANES x WIDTH output data, same packing as i_tdata
//   o_tuser    LANES x USER_WIDTH output user bits
//   o_tlast    per-lane output last
//   o_tvalid   per-lane output valid (~empty)
//   o_tready   per-lane output ready from the consumer
//   occupancy  per-lane entry count, lane k at [(DEPTH_LOG2+1)*k +: DEPTH_LOG2+1]
// ---------------------------------------------------------------------------
module multi_stream_fifo_bank #(
  parameter int WIDTH      = 16,
  parameter int USER_WIDTH = 2,
  parameter int LANES      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic [WIDTH*LANES-1:0]           i_tdata,
  input  logic [USER_WIDTH*LANES-1:0]      i_tuser,
  input  logic [LANES-1:0]                 i_tlast,
  input  logic [LANES-1:0]                 i_tvalid,
  output logic [LANES-1:0]                 i_tready,
  output logic [WIDTH*LANES-1:0]           o_tdata,
  output logic [USER_WIDTH*LANES-1:0]      o_tuser,
  output logic [LANES-1:0]                 o_tlast,
  output logic [LANES-1:0]                 o_tvalid,
  input  logic [LANES-1:0]                 o_tready,
  output logic [(DEPTH_LOG2+1)*LANES-1:0]  occupancy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int EW    = WIDTH + USER_WIDTH + 1;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] rd_word;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    // The pointers carry one extra wrap bit. Equal pointers mean empty.
    // Pointers with the same index but a different wrap bit mean full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);

    // Handshakes qualify only against registered state. A pop in a full
    // cycle frees the slot on the next cycle, not in this one.
    assign push = i_tvalid[k] & ~full;
    assign pop  = o_tready[k] & ~empty;

    // Next pointer values. clear wins over any push or pop in the same cycle.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end else begin
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end

    // Storage has no reset and is written only on an accepted push, so it can
    // map onto distributed RAM. The word offered during a clear is dropped.
    always_ff @(posedge clk) begin
      if (push && !clear) begin
        mem_q[wr_ptr_q[PW-2:0]] <= {i_tlast[k],
                                    i_tuser[USER_WIDTH*k +: USER_WIDTH],
                                    i_tdata[WIDTH*k +: WIDTH]};
      end
    end

    // First-word fall-through: the head entry is always on the outputs.
    assign rd_word = mem_q[rd_ptr_q[PW-2:0]];

    assign o_tdata[WIDTH*k +: WIDTH]           = rd_word[WIDTH-1:0];
    assign o_tuser[USER_WIDTH*k +: USER_WIDTH] = rd_word[WIDTH +: USER_WIDTH];
    assign o_tlast[k]                          = rd_word[EW-1];
    assign o_tvalid[k]                         = ~empty;
    assign i_tready[k]                         = ~full;
    assign occupancy[PW*k +: PW]               = wr_ptr_q - rd_ptr_q;
  end

endmodule

// File: doc/multi_stream_fifo_bank.md
Name: multi_stream_fifo_bank

Overview:
Bank of LANES independent small FIFOs, one per output of the broadcast splitter. Placed directly downstream of the splitter so that each lane's o_tvalid depends only on stored state, never on a consumer's tready. This restores AXI-compliant handshakes in front of muxes and demuxes and removes the deadlock hazard. Each lane buffers tdata, tuser and tlast together and reports its occupancy.

Parameters:
WIDTH, 16, tdata width per lane
USER_WIDTH, 2, tuser width per lane
LANES, 4, number of independent lanes (matches splitter OUTPUTS)
DEPTH_LOG2, 2, log2 of per-lane FIFO depth (depth = 2**DEPTH_LOG2, DEPTH_LOG2 >= 1)

Ports:
clk  in  1  single clock for all lanes
reset_n  in  1  asynchronous reset, active-low
clear  in  1  synchronous flush of all lanes, active-high
i_tdata  in  WIDTH*LANES  lane k at [WIDTH*k +: WIDTH]
i_tuser  in  USER_WIDTH*LANES  lane k at [USER_WIDTH*k +: USER_WIDTH]
i_tlast  in  LANES  per-lane last
i_tvalid  in  LANES  per-lane valid
i_tready  out  LANES  per-lane ready
o_tdata  out  WIDTH*LANES  same packing as i_tdata
o_tuser  out  USER_WIDTH*LANES  same packing as i_tuser
o_tlast  out  LANES  per-lane last
o_tvalid  out  LANES  per-lane valid
o_tready  in  LANES  per-lane ready
occupancy  out  (DEPTH_LOG2+1)*LANES  lane k entry count at [(DEPTH_LOG2+1)*k +: DEPTH_LOG2+1]

Behaviour:
- Lanes are fully independent. There is no cross-lane coupling except the shared clk, reset_n and clear.
- Per-lane state: storage of DEPTH words of {tlast, tuser, tdata}, plus wr_ptr and rd_ptr, each DEPTH_LOG2+1 bits wide with a wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = (MSBs differ) and (lower DEPTH_LOG2 bits equal).
- occupancy = wr_ptr - rd_ptr, modulo 2**(DEPTH_LOG2+1). Range is 0..DEPTH.
- i_tready[k] = ~full. o_tvalid[k] = ~empty. Both are functions of registered state only:
  - i_tready never depends on i_tvalid or o_tready.
  - o_tvalid never depends on o_tready or i_tvalid.
- Push: when i_tvalid & i_tready, write the word at wr_ptr and increment wr_ptr.
- Pop: when o_tvalid & o_tready, increment rd_ptr.
- Outputs are first-word fall-through. o_tdata, o_tuser and o_tlast show the word at rd_ptr combinationally from storage.
  - When o_tvalid = 0, output data values are don't-care.
- Latency: a word accepted at edge N is presented with o_tvalid = 1 after edge N. There is no same-cycle bypass when empty.
- Simultaneous push and pop, not full and not empty: both occur and occupancy is unchanged.
- Full: i_tready = 0, so no push. A pop in that cycle frees one entry, and i_tready = 1 on the next cycle. There is no same-cycle push-through.
- Empty: o_tvalid = 0, so no pop. A push makes o_tvalid = 1 next cycle.
- Pointer wrap: index bits wrap modulo DEPTH and the MSB toggles. Throughput is one word per cycle per lane when both sides are ready and 0 < occupancy < DEPTH.
- Ordering and packet integrity: words leave in strict arrival order, and tlast/tuser stay with their data word. The block does no packet-level processing.
- clear (synchronous):
  - At an edge with clear = 1, all pointers go to 0 in all lanes.
  - clear overrides any push or pop in that cycle. The word offered is not stored and the pop is discarded.
  - Storage contents are not erased.
  - After the edge: o_tvalid = 0, i_tready = 1, occupancy = 0.
- Reset (reset_n low):
  - Pointers go to 0 asynchronously, which forces o_tvalid = 0, i_tready = 1 and occupancy = 0 immediately.
  - Storage is not reset.
  - Asserting reset mid-transfer drops all buffered words.
  - Normal operation resumes at the first rising edge after reset_n deasserts.
- Storage is written only on push and has no reset, so it may map to distributed RAM.

Test Plan:
- Reset and idle: hold reset_n low with i_tvalid all 1 -> o_tvalid = 0, i_tready = 4'b1111, occupancy all 0. Release reset -> lane 0 receives 0x0001 and o_tvalid[0] rises one cycle later.
- Fill to full: DEPTH_LOG2 = 2, lane 1 o_tready = 0, push 0x10..0x13 -> occupancy[lane1] = 4, i_tready[1] = 0. A fifth word is held off. Pop once -> i_tready[1] = 1 on the next cycle. Data emerges in order 0x10, 0x11, 0x12, 0x13, 0x14.
- Streaming and wrap: lane 2 with both sides continuously ready, 20 words 0x100..0x113 with tlast on 0x107 and 0x113, tuser = word[1:0] -> one word per cycle, occupancy stays 1, and order, tlast and tuser are preserved across several pointer wraps.
- Lane independence and backpressure: splitter drives all lanes; lane 3 o_tready toggles randomly, other lanes stay ready -> lanes 0–2 never stall. Lane 3 stalls only its own i_tready. All lanes deliver an identical sequence.
- Clear mid-operation: lane 0 holds 3 words; assert clear for one cycle with a simultaneous push of 0xAA and o_tready = 1 -> after the edge occupancy = 0, o_tvalid = 0, and 0xAA is never output. The next push of 0xBB is output first.
- Async reset mid-packet: lane 0 has 2 words buffered; pulse reset_n low between clock edges -> o_tvalid[0] drops before the next edge, and the buffered words are never output.
